// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bus between producer blocks and the FIFO write arbiter.
//   req       : per-requester valid, held together with its data until granted
//   req_data  : packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full : FIFO full flag in the write-clock domain
//   gnt       : one-hot ready back to the requesters
//   wr_en     : memory write enable
//   wr_data   : memory write data (0 when wr_en=0)
//   owner     : index of the current burst owner
//   busy      : high while a burst is in progress (FSM state)
// Handshake: word i moves on a rising clk edge where req[i] & gnt[i] is high;
// a requester keeps req[i] and its data stable until that edge, and gnt may
// depend combinationally on req within the same cycle.
// Modports: master = producer/FIFO side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            gnt;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [ID_WIDTH-1:0]           owner;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, wr_en, wr_data, owner, busy
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, wr_en, wr_data, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO memory write port among NUM_REQ
// requesters. A grant gives one requester a burst of up to MAX_BURST words;
// every burst is followed by one IDLE cycle in which the next winner is picked.
// Ports:
//   clk   : write-side clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_wr_arbiter_if slave modport (req/req_data/fifo_full in,
//           gnt/wr_en/wr_data/owner/busy out; busy mirrors the FSM state)
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_wr_arbiter_if.slave    bus
);

  localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr, rr_nxt;
  logic [ID_WIDTH-1:0] owner_q, owner_nxt;
  logic [CNT_W-1:0]    burst_cnt, cnt_nxt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int                   win_off;
  logic [ID_WIDTH-1:0]  winner;
  logic                 owner_req;
  logic [DATA_WIDTH-1:0] owner_data;

  // Rotate req so that bit 0 is the requester at rr_ptr; the lowest set bit
  // of the rotated vector is the winner's distance from rr_ptr.
  always_comb begin
    req_dbl = {bus.req, bus.req} >> rr_ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    win_off = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) win_off = j;
    end
    winner = ID_WIDTH'((int'(rr_ptr) + win_off) % NUM_REQ);
  end

  // Owner's request and data, selected by comparison to avoid index-width issues.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_WIDTH'(i)) begin
        owner_req  = bus.req[i];
        owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_q   <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner_q   <= owner_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    owner_nxt   = owner_q;
    cnt_nxt     = burst_cnt;
    bus.gnt     = '0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_nxt = winner;
          rr_nxt    = ID_WIDTH'((int'(winner) + 1) % NUM_REQ);
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        // fifo_full is used combinationally so no write is issued while full.
        for (int i = 0; i < NUM_REQ; i++) begin
          bus.gnt[i] = (owner_q == ID_WIDTH'(i)) && !bus.fifo_full;
        end
        bus.wr_en   = owner_req && !bus.fifo_full;
        bus.wr_data = bus.wr_en ? owner_data : '0;
        if (!owner_req) begin
          state_nxt = IDLE;
        end else if (bus.wr_en) begin
          if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = burst_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.owner = owner_q;
  assign bus.busy  = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .ID_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int words_left [NR];
  logic [DW-1:0] cur_data [NR];
  logic full_in;
  int wr_count;
  logic [15:0] wr_pat;

  // reference model: who owns the port, how many words it has moved, next start point
  bit m_busy;
  int m_owner, m_cnt, m_rr;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i] = (words_left[i] > 0);
      bus.req_data[i*DW +: DW] = cur_data[i];
    end
    bus.fifo_full = full_in;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    full_in = 1'b0;
    for (int i = 0; i < NR; i++) begin
      words_left[i] = 0;
      cur_data[i] = DW'($urandom);
    end
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_count = 0;
    wr_pat = '0;
  endtask

  // One clock cycle: compare at negedge, advance model, update producers after posedge.
  task automatic cycle();
    bit e_wr;
    logic [NR-1:0] e_gnt;
    logic [DW-1:0] e_data;
    int own;
    bit found;
    @(negedge clk);
    own = m_owner;
    e_gnt = '0; e_wr = 0; e_data = '0;
    if (m_busy && !full_in) begin
      e_gnt[own] = 1'b1;
      e_wr = (words_left[own] > 0);
      if (e_wr) e_data = cur_data[own];
    end
    check("busy",    32'(bus.busy),    32'(m_busy));
    check("owner",   32'(bus.owner),   32'(own));
    check("gnt",     32'(bus.gnt),     32'(e_gnt));
    check("wr_en",   32'(bus.wr_en),   32'(e_wr));
    check("wr_data", 32'(bus.wr_data), 32'(e_data));
    if (e_wr) exp_q.push_back(cur_data[own]);
    if (bus.wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() > 0) check("sb_data", 32'(bus.wr_data), 32'(exp_q.pop_front()));
      else check("sb_underflow", 32'(bus.wr_en), 32'd0);
    end
    wr_pat = {wr_pat[14:0], bus.wr_en};
    // next model state from the arbitration rules
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_rr + k) % NR;
        if (!found && words_left[idx] > 0) begin
          found = 1;
          m_owner = idx;
          m_rr = (idx + 1) % NR;
          m_cnt = 0;
          m_busy = 1;
        end
      end
    end else if (words_left[own] == 0) begin
      m_busy = 0;
    end else if (e_wr) begin
      m_cnt++;
      if (m_cnt == MB) begin
        m_busy = 0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    if (e_wr) begin
      words_left[own]--;
      cur_data[own] = DW'($urandom);
    end
    drive();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    full_in = 1'b0;
    for (int i = 0; i < NR; i++) begin
      words_left[i] = 1;
      cur_data[i] = DW'($urandom);
    end
    drive();
    #1;
    check("rst_busy",  32'(bus.busy),    32'd0);
    check("rst_gnt",   32'(bus.gnt),     32'd0);
    check("rst_wr_en", 32'(bus.wr_en),   32'd0);
    check("rst_data",  32'(bus.wr_data), 32'd0);
    check("rst_owner", 32'(bus.owner),   32'd0);

    // single requester, 6 words: bursts of 4 then 2 with one idle between
    do_reset();
    words_left[0] = 6; drive();
    repeat (9) cycle();
    check("t1_pattern", 32'(wr_pat[8:0]), 32'b011110110);
    check("t1_writes",  32'(wr_count),   32'd6);

    // all requesting: owners 0,1,2,3 in turn, 4 writes each
    do_reset();
    for (int i = 0; i < NR; i++) words_left[i] = 1000;
    drive();
    repeat (20) cycle();
    check("t2_writes", 32'(wr_count), 32'd16);
    repeat (2) cycle();
    check("t2_wrap_owner", 32'(bus.owner), 32'd0);

    // full for 3 cycles in the middle of requester 1's burst
    do_reset();
    words_left[1] = 4; drive();
    for (int c = 0; c < 9; c++) begin
      full_in = (c >= 3 && c <= 5);
      drive();
      cycle();
    end
    check("t3_writes", 32'(wr_count), 32'd4);
    check("t3_idle",   32'(bus.busy), 32'd0);

    // owner drops after one word, requester 2 pending
    do_reset();
    words_left[0] = 1; words_left[2] = 3; drive();
    repeat (4) cycle();
    check("t4_owner", 32'(bus.owner), 32'd2);
    check("t4_busy",  32'(bus.busy),  32'd1);
    words_left[0] = 2; words_left[3] = 2; drive();
    repeat (8) cycle();

    // async reset mid-burst with owner 3
    do_reset();
    words_left[3] = 5; drive();
    repeat (3) cycle();
    check("t5_pre_owner", 32'(bus.owner), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_busy", 32'(bus.busy),    32'd0);
    check("t5_async_gnt",  32'(bus.gnt),     32'd0);
    check("t5_async_wr",   32'(bus.wr_en),   32'd0);
    check("t5_async_data", 32'(bus.wr_data), 32'd0);
    do_reset();
    words_left[0] = 2; words_left[3] = 2; drive();
    repeat (2) cycle();
    check("t5_owner", 32'(bus.owner), 32'd0);
    repeat (6) cycle();

    // full held: burst entered but no writes until full drops
    do_reset();
    full_in = 1'b1; words_left[2] = 4; drive();
    repeat (6) cycle();
    check("t6_no_write", 32'(wr_count),  32'd0);
    check("t6_owner",    32'(bus.owner), 32'd2);
    full_in = 1'b0; drive();
    repeat (6) cycle();
    check("t6_writes", 32'(wr_count), 32'd4);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (words_left[i] == 0 && $urandom_range(0, 5) == 0)
          words_left[i] = int'($urandom_range(1, 9));
      end
      full_in = ($urandom_range(0, 4) == 0);
      drive();
      cycle();
    end
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
